// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: op encodings, flag bit positions, widths.
`timescale 1ns/1ps
package alu_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned SHAMT_W  = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [2:0] {
    SUB = 3'b000,
    AND = 3'b001,
    ADD = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SLL = 3'b101,
    SRL = 3'b110,
    SRA = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu16_addsub.sv
// Shared adder/subtractor: A + (B or ~B) + sub, with carry-out and signed overflow.
`timescale 1ns/1ps
module alu16_addsub
  import alu_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         c_o,
  output logic         v_o
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum_full;

  // Subtraction reuses the adder as A + ~B + 1; carry-out then means "no borrow".
  assign b_eff    = sub_i ? ~b_i : b_i;
  assign sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
  assign sum_o    = sum_full[W-1:0];
  assign c_o      = sum_full[W];

  // Overflow when both adder inputs share a sign that the sum does not.
  assign v_o = (a_i[W-1] == b_eff[W-1]) && (sum_o[W-1] != a_i[W-1]);

endmodule

// File: rtl/alu16.sv
// 16-bit EX-stage ALU: op decode, flag generation, optional output register.
// Build option: define ALU_OUT_REG_EN to register result/status (1-cycle latency);
// otherwise the ALU is purely combinational and clk/rst_n are unused.
`timescale 1ns/1ps
module alu16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] result
);

  import alu_pkg::*;

  alu_op_e                op_e;
  logic [SHAMT_W-1:0]     shamt;
  logic [WIDTH-1:0]       as_sum;
  logic                   as_c;
  logic                   as_v;
  logic                   is_arith;
  logic [WIDTH-1:0]       result_c;
  logic [WIDTH-1:0]       status_c;

  assign op_e     = alu_op_e'(op);
  assign shamt    = in2[SHAMT_W-1:0];
  assign is_arith = (op_e == SUB) || (op_e == ADD);

  alu16_addsub #(
    .W (WIDTH)
  ) u_addsub (
    .a_i   (in1),
    .b_i   (in2),
    .sub_i (op_e == SUB),
    .sum_o (as_sum),
    .c_o   (as_c),
    .v_o   (as_v)
  );

  // Result mux; every encoding of the 3-bit op is a defined operation.
  always_comb begin
    result_c = '0;
    unique case (op_e)
      SUB, ADD: result_c = as_sum;
      AND:      result_c = in1 & in2;
      OR:       result_c = in1 | in2;
      XOR:      result_c = in1 ^ in2;
      SLL:      result_c = in1 << shamt;
      SRL:      result_c = in1 >> shamt;
      SRA:      result_c = WIDTH'($signed(in1) >>> shamt);
      default:  result_c = '0;
    endcase
  end

  // Flags: Z/N from the result for every op, C/V only from the adder ops.
  always_comb begin
    status_c         = '0;
    status_c[FLAG_Z] = (result_c == '0);
    status_c[FLAG_N] = result_c[WIDTH-1];
    status_c[FLAG_C] = is_arith & as_c;
    status_c[FLAG_V] = is_arith & as_v;
  end

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] status_q;

  // Output register, reloaded every cycle; reset clears flags too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_c;
      status_q <= status_c;
    end
  end

  assign result = result_q;
  assign status = status_q;
`else
  logic unused_clk_rst;

  // Zero-latency path; clock and reset are kept only for port compatibility.
  assign unused_clk_rst = clk ^ rst_n;
  assign result         = result_c;
  assign status         = status_c;
`endif

endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16; adapts to the registered build when ALU_OUT_REG_EN is set.
`timescale 1ns/1ps
module tb_alu16;

`ifdef ALU_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] st;
    logic [15:0] res;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in1, in2, status, result;
  logic [2:0]  op;

  int unsigned errors = 0;
  int unsigned checks = 0;
  sb_t         exp_q[$];

  always #5 clk = ~clk;

  alu16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in1    (in1),
    .in2    (in2),
    .status (status),
    .result (result)
    ,.op    (op)
  );

  // Independent reference: integer arithmetic, range checks for overflow.
  function automatic sb_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    sb_t         e;
    int          sa, sb, s;
    int unsigned ua, ub, sh;
    logic [15:0] r;
    logic        c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = b[3:0];
    c = 1'b0; v = 1'b0; r = 16'h0;
    case (o)
      3'd0: begin r = 16'(ua - ub); c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
      3'd1: r = a & b;
      3'd2: begin r = 16'(ua + ub); c = (ua + ub) > 32'd65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: r = 16'($signed(a) >>> sh);
    endcase
    e.op = o; e.a = a; e.b = b; e.res = r;
    e.st = {12'h0, v, c, r[15], (r == 16'h0)};
    return e;
  endfunction

  // Drive one vector just after a rising edge and record what it must produce.
  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input sb_t e);
    @(posedge clk); #1;
    op = o; in1 = a; in2 = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [15:0] er, es;
    rst_n = 1'b0; op = 3'd0; in1 = 16'h0; in2 = 16'h0;
    #2;
`ifdef ALU_OUT_REG_EN
    er = 16'h0000; es = 16'h0000;
`else
    er = 16'h0000; es = 16'h0005;
`endif
    checks++;
    if (result !== er || status !== es) begin
      errors++;
      $display("FAIL reset_idle: got status=%h result=%h want status=%h result=%h", status, result, es, er);
    end
    op = 3'd2; in1 = 16'h0001; in2 = 16'h0001;
    @(posedge clk); #1;
`ifdef ALU_OUT_REG_EN
    er = 16'h0000; es = 16'h0000;
`else
    er = 16'h0002; es = 16'h0000;
`endif
    checks++;
    if (result !== er || status !== es) begin
      errors++;
      $display("FAIL reset_hold: got status=%h result=%h want status=%h result=%h", status, result, es, er);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    sb_t tbl[18];
    sb_t e;
    tbl[0]  = '{3'd2, 16'h4444, 16'h4443, 16'h000A, 16'h8887};
    tbl[1]  = '{3'd0, 16'hFFFD, 16'hFFFD, 16'h0005, 16'h0000};
    tbl[2]  = '{3'd0, 16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
    tbl[3]  = '{3'd2, 16'h0040, 16'h0006, 16'h0000, 16'h0046};
    tbl[4]  = '{3'd1, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0};
    tbl[5]  = '{3'd3, 16'hF0F0, 16'h0FF0, 16'h0002, 16'hFFF0};
    tbl[6]  = '{3'd4, 16'hF0F0, 16'h0FF0, 16'h0002, 16'hFF00};
    tbl[7]  = '{3'd5, 16'h0001, 16'h000F, 16'h0002, 16'h8000};
    tbl[8]  = '{3'd6, 16'h8000, 16'h0004, 16'h0000, 16'h0800};
    tbl[9]  = '{3'd7, 16'h8000, 16'h0004, 16'h0002, 16'hF800};
    tbl[10] = '{3'd5, 16'h1234, 16'h0010, 16'h0000, 16'h1234};
    tbl[11] = '{3'd7, 16'h8001, 16'h0010, 16'h0002, 16'h8001};
    tbl[12] = '{3'd6, 16'hA5A5, 16'hFFF0, 16'h0002, 16'hA5A5};
    tbl[13] = '{3'd2, 16'hFFFF, 16'h0001, 16'h0005, 16'h0000};
    tbl[14] = '{3'd2, 16'h7FFF, 16'h0001, 16'h000A, 16'h8000};
    tbl[15] = '{3'd0, 16'h8000, 16'h0001, 16'h000C, 16'h7FFF};
    tbl[16] = '{3'd0, 16'h0005, 16'h0003, 16'h0004, 16'h0002};
    tbl[17] = '{3'd1, 16'hAAAA, 16'h5555, 16'h0001, 16'h0000};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i]);
      @(negedge clk);
      if (exp_q.size() > LAT) begin
        e = exp_q.pop_front();
        checks++;
        if (status !== e.st || result !== e.res) begin
          errors++;
          $display("FAIL directed op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                   e.op, e.a, e.b, status, result, e.st, e.res);
        end
      end
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (status !== e.st || result !== e.res) begin
        errors++;
        $display("FAIL directed_drain op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                 e.op, e.a, e.b, status, result, e.st, e.res);
      end
    end
  endtask

  task automatic test_random();
    sb_t         e;
    logic [2:0]  o;
    logic [15:0] a, b;
    for (int i = 0; i < 200; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if ((i % 5) == 0) b = a;
      if ((i % 7) == 0) a = 16'h8000;
      if ((i % 11) == 0) b = 16'h7FFF;
      drive(o, a, b, model(o, a, b));
      @(negedge clk);
      if (exp_q.size() > LAT) begin
        e = exp_q.pop_front();
        checks++;
        if (status !== e.st || result !== e.res) begin
          errors++;
          $display("FAIL random op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                   e.op, e.a, e.b, status, result, e.st, e.res);
        end
      end
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (status !== e.st || result !== e.res) begin
        errors++;
        $display("FAIL random_drain op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                 e.op, e.a, e.b, status, result, e.st, e.res);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t         e;
    logic [2:0]  o;
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'(i % 8);
      a = 16'(i * 16'h1357 + 3);
      b = 16'(i * 16'h0B03 + i);
      drive(o, a, b, model(o, a, b));
      @(negedge clk);
      if (exp_q.size() > LAT) begin
        e = exp_q.pop_front();
        checks++;
        if (status !== e.st || result !== e.res) begin
          errors++;
          $display("FAIL back_to_back op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                   e.op, e.a, e.b, status, result, e.st, e.res);
        end
      end
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (status !== e.st || result !== e.res) begin
        errors++;
        $display("FAIL b2b_drain op=%0d a=%h b=%h: got status=%h result=%h want status=%h result=%h",
                 e.op, e.a, e.b, status, result, e.st, e.res);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] er, es;
    @(posedge clk); #1;
    op = 3'd2; in1 = 16'h4444; in2 = 16'h4443;
    @(posedge clk); #1;
    checks++;
    if (result !== 16'h8887 || status !== 16'h000A) begin
      errors++;
      $display("FAIL pre_reset: got status=%h result=%h want status=000a result=8887", status, result);
    end
    rst_n = 1'b0;
    #1;
`ifdef ALU_OUT_REG_EN
    er = 16'h0000; es = 16'h0000;
`else
    er = 16'h8887; es = 16'h000A;
`endif
    checks++;
    if (result !== er || status !== es) begin
      errors++;
      $display("FAIL mid_reset: got status=%h result=%h want status=%h result=%h", status, result, es, er);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result !== 16'h8887 || status !== 16'h000A) begin
      errors++;
      $display("FAIL post_reset: got status=%h result=%h want status=000a result=8887", status, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish before 500000ns");
    $fatal(1);
  end

endmodule
